// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer
// Description : Parallel-to-serial front end for the sequence recognizer.
//               Accepts W-bit words over valid/ready and emits them one bit
//               per clock on x_o, with a one-word holding register so that
//               back-to-back words stream with no idle bit between them.
//               Build option: SERIALIZER_LSB_FIRST_EN selects LSB-first
//               output (default is MSB-first).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_serializer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] din_i,
    input  logic         din_valid_i,
    output logic         din_ready_o,
    output logic         x_o,
    output logic         x_valid_o,
    output logic         busy_o
);

    localparam int                  C_BCNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [C_BCNT_W-1:0] C_LAST   = C_BCNT_W'(W - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              st_q,        st_d;
    logic [W-1:0]        hold_q,      hold_d;
    logic                hold_full_q, hold_full_d;
    logic [W-1:0]        sreg_q,      sreg_d;
    logic [C_BCNT_W-1:0] bcnt_q,      bcnt_d;
    logic                x_q,         x_d;
    logic                x_valid_q,   x_valid_d;

    logic                w_load;
    logic                w_accept;
    logic [W-1:0]        w_shifted;

    // Hand the held word to the shifter when idle or on the last bit of the
    // current word; a load frees the holding register in the same cycle.
    assign w_load      = hold_full_q & ((st_q == ST_IDLE) | (bcnt_q == C_LAST));
    assign din_ready_o = ~hold_full_q | w_load;
    assign w_accept    = din_valid_i & din_ready_o;

`ifdef SERIALIZER_LSB_FIRST_EN
    assign w_shifted = {1'b0, sreg_q[W-1:1]};
`else
    assign w_shifted = {sreg_q[W-2:0], 1'b0};
`endif

    // State register plus registered serial outputs; reset clears everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q        <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sreg_q      <= '0;
            bcnt_q      <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
        end else begin
            st_q        <= st_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sreg_q      <= sreg_d;
            bcnt_q      <= bcnt_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
        end
    end

    // Next-state for holding register, shifter, bit counter and outputs.
    always_comb begin
        st_d        = st_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sreg_d      = sreg_q;
        bcnt_d      = bcnt_q;
        x_d         = 1'b0;
        x_valid_d   = 1'b0;

        // A new word always lands in hold; otherwise a load empties it.
        if (w_accept) begin
            hold_d      = din_i;
            hold_full_d = 1'b1;
        end else if (w_load) begin
            hold_full_d = 1'b0;
        end

        case (st_q)
            ST_IDLE: begin
                if (w_load) begin
                    sreg_d = hold_q;
                    bcnt_d = '0;
                    st_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_load) begin
                    sreg_d = hold_q;
                    bcnt_d = '0;
                end else if (bcnt_q == C_LAST) begin
                    sreg_d = w_shifted;
                    bcnt_d = '0;
                    st_d   = ST_IDLE;
                end else begin
                    sreg_d = w_shifted;
                    bcnt_d = bcnt_q + C_BCNT_W'(1);
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase

        // Outputs are registered versions of what the next state presents.
        if (st_d == ST_SHIFT) begin
            x_valid_d = 1'b1;
`ifdef SERIALIZER_LSB_FIRST_EN
            x_d       = sreg_d[0];
`else
            x_d       = sreg_d[W-1];
`endif
        end
    end

    assign x_o       = x_q;
    assign x_valid_o = x_valid_q;
    assign busy_o    = (st_q == ST_SHIFT) | hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_serializer
// Description : Self-checking bench for seq_serializer: reset values, a
//               cycle table for one word, back-to-back streaming,
//               backpressure, mid-word reset and randomized traffic against
//               a bit-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         x;
    logic         x_valid;
    logic         busy;

    int errors = 0;
    int checks = 0;

    seq_serializer #(.W(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .din_i       (din),
        .din_valid_i (din_valid),
        .din_ready_o (din_ready),
        .x_o         (x),
        .x_valid_o   (x_valid),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position i of the serial stream for word w.
    function automatic logic stream_bit(input logic [W-1:0] w, input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
        return w[i];
`else
        return w[W-1-i];
`endif
    endfunction

    // ------------------------------------------------------------------
    // Reference model: every accepted word appends W bits to a queue.
    // Bits leave one per cycle; a word accepted into an empty block costs
    // one dead cycle before its first bit. Pending bits beyond the current
    // word's last bit plus one full held word mean din_ready must be low.
    // ------------------------------------------------------------------
    logic q_bits[$];
    bit   gap     = 1'b0;
    int   run     = 0;
    int   max_run = 0;

    always @(negedge clk) begin
        int  len;
        bit  exp_xv;
        if (!rst_n) begin
            q_bits.delete();
            gap = 1'b0;
            run = 0;
            chk("rst_x", x, 1'b0);
            chk("rst_xv", x_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end else begin
            len    = q_bits.size();
            exp_xv = (len > 0) && !gap;
            chk("mon_xv", x_valid, exp_xv);
            chk("mon_busy", busy, len > 0);
            chk("mon_ready", din_ready, len <= W + 1);
            if (exp_xv) begin
                chk("mon_x", x, q_bits[0]);
                void'(q_bits.pop_front());
            end else begin
                chk("mon_x_idle", x, 1'b0);
            end
            if (x_valid) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            gap = 1'b0;
            if (din_valid && din_ready) begin
                if (q_bits.size() == 0) gap = 1'b1;
                for (int i = 0; i < W; i++) q_bits.push_back(stream_bit(din, i));
            end
        end
    end

    // Offer one word and hold it until accepted; reports stalled cycles.
    task automatic send(input logic [W-1:0] w, output int stalls);
        bit ok;
        ok        = 1'b0;
        stalls    = 0;
        din       = w;
        din_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (din_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (q_bits.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         ex;
        logic         exv;
        logic         ebusy;
        logic         erdy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int          st;
        logic [W-1:0] word;

        rst_n     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        chk("reset_x", x, 1'b0);
        chk("reset_xv", x_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", din_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single word B4: one dead cycle, 8 payload bits, then idle.
        word = 8'hB4;
        tbl[0] = '{1'b1, word, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 1; k <= W; k++)
            tbl[k] = '{1'b0, '0, stream_bit(word, k - 1), 1'b1, 1'b1, 1'b1};
        tbl[W+1] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < W + 2; k++) begin
            din_valid = tbl[k].v;
            din       = tbl[k].d;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_x", k), x, tbl[k].ex);
            chk($sformatf("tbl%0d_xv", k), x_valid, tbl[k].exv);
            chk($sformatf("tbl%0d_busy", k), busy, tbl[k].ebusy);
            chk($sformatf("tbl%0d_ready", k), din_ready, tbl[k].erdy);
        end
        drain();

        // Three words offered continuously must stream as 24 gapless bits.
        max_run = 0;
        send(8'hB4, st);
        send(8'h2D, st);
        send(8'hFF, st);
        chk("b2b_stalled", st > 0, 1'b1);
        drain();
        chk("b2b_run", max_run, 3 * W);

        // Backpressure: third word waits for the last bit of the first.
        send(8'hA5, st);
        send(8'h3C, st);
        send(8'h81, st);
        chk("bp_stalls", st, W - 1);
        drain();

        // Mid-word reset with a second word held.
        send(8'hB4, st);
        send(8'h2D, st);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_x", x, 1'b0);
        chk("mid_rst_xv", x_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", din_ready, 1'b1);
        din       = 8'hC3;
        din_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        din_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_xv", x_valid, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        send(8'h5A, st);
        drain();

        // Randomized traffic with random idle gaps.
        for (int n = 0; n < 150; n++) begin
            int gapc;
            gapc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            repeat (gapc) @(posedge clk);
            if (gapc > 0) #1;
            send(W'($urandom), st);
        end
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the sequence recognizer. It accepts W-bit words over a valid/ready handshake and emits them one bit per clock on `x`, which feeds the recognizer's serial input directly. A one-word holding register lets back-to-back words stream with no idle bit between them. `x_valid` marks bits that carry payload.

## Interface
- `W`, default 8: word width in bits, W ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low. Asserted (0) clears all state immediately. Release is synchronous to `clk`.
- `din`  in  W  parallel word.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  the block can accept a word this cycle. A word transfers on a rising edge where `din_valid & din_ready` is high.
- `x`  out  1  serial bit to the recognizer. Registered.
- `x_valid`  out  1  `x` carries a payload bit this cycle. Registered.
- `busy`  out  1  the shifter or the holding register is occupied.

## Operation
- Storage:
  - Holding register `hold` (W bits) plus a `hold_full` flag.
  - Shift register `sreg` (W bits).
  - Bit counter `bcnt`, width clog2(W).
  - State `st` ∈ {IDLE, SHIFT}.
- Accept:
  - `din_ready = !hold_full | load`. This path is combinational.
  - An accepted word always lands in `hold`, and `hold_full` sets.
- `load = hold_full & (st==IDLE | (st==SHIFT & bcnt==W-1))`.
- On `load`:
  - `sreg <= hold`, `bcnt <= 0`, `st <= SHIFT`.
  - `hold_full` clears unless a new word is accepted in the same cycle. In that case `hold` takes the new word and `hold_full` stays 1.
- In SHIFT:
  - `x` presents `sreg[W-1]` (MSB-first).
  - Each cycle the register shifts left by 1, zero-filled, and `bcnt` increments.
  - At `bcnt==W-1` with no `load`, go to IDLE.
- State transitions:
  - IDLE→SHIFT on `load`.
  - SHIFT→SHIFT on `load` at the last bit (gapless), or while `bcnt<W-1`.
  - SHIFT→IDLE at the last bit with `hold_full=0`.
- Outputs:
  - `x_valid = (st==SHIFT)`.
  - In IDLE, `x` is 0.
  - `busy = (st==SHIFT) | hold_full`.
- The recognizer sees `x=0` during idle gaps. This is intended: gaps are treated as zero bits by the downstream FSM.

## Timing
- Reset values:
  - `x=0`, `x_valid=0`, `busy=0`, `din_ready=1`.
  - `st=IDLE`, `hold_full=0`, `bcnt=0`, `sreg=0`.
- Latency from an empty block:
  - Word accepted at edge N.
  - `load` at edge N+1.
  - First bit on `x` (with `x_valid=1`) in the cycle after edge N+1.
  - Last bit follows W-1 cycles after the first.
- Sustained throughput:
  - One word per W cycles with zero gap cycles, provided the next word is accepted before the current word's last bit.
- Backpressure:
  - `din_ready` is low only when `hold_full=1` and no `load` occurs that cycle.
  - The source must hold `din` and `din_valid` stable until the transfer.
- Simultaneous events:
  - Accept and `load` in the same cycle is legal. `hold` is refilled while `sreg` takes the old word.
- Reset mid-word:
  - All state clears asynchronously.
  - The partial word and any held word are discarded.
  - `x` and `x_valid` drop to 0 immediately.
  - No bit is emitted after release until a new word is accepted.
- A `din_valid` pulse while `rst=0` is ignored.

## Configuration
- `SERIALIZER_LSB_FIRST_EN`:
  - Defined: `x` presents `sreg[0]`, and the register shifts right with zero fill. Words leave LSB-first.
  - Undefined (default): MSB-first, as described above.
- Handshake, latency and throughput are identical in both modes.

## Test plan
- Reset release, then one word `din=8'hB4` → `x` = 1,0,1,1,0,1,0,0 over 8 cycles with `x_valid=1`. `busy` drops the cycle after the last bit. The downstream recognizer's `y` pulses after the 6th bit (101101).
- Three words `8'hB4, 8'h2D, 8'hFF` offered continuously → 24 consecutive cycles with `x_valid=1` and no gap. `din_ready` is low for one or more cycles while `hold_full` waits for `load`.
- Hold `din_valid=1` with a word pending while the shifter is mid-word → `din_ready=0` until the last-bit cycle. The transfer happens exactly at that `load` edge.
- Assert `rst=0` at bit 3 of `8'hB4` with a second word held → `x`, `x_valid` and `busy` go to 0 immediately. After release, nothing is emitted until a new word is accepted.
- With `SERIALIZER_LSB_FIRST_EN` defined, `din=8'h2D` → `x` = 1,0,1,1,0,1,0,0 (LSB-first). The recognizer's `y` fires after the 6th bit.
